// File: rtl/mips_multicycle_controller.sv
// Multi-cycle MIPS control unit: combinational step/opcode decode of all
// datapath strobes and the ALU function code, plus a sticky bad-opcode flag.
module mips_multicycle_controller (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic [2:0] state,
  output logic       MemToReg,
  output logic       RegDst,
  output logic       IorD,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic       IRWrite,
  output logic       MemWrite,
  output logic       PCWrite,
  output logic       Branch,
  output logic       RegWrite,
  output logic [1:0] ALUOp,
  output logic [2:0] ALUControl,
  output logic       next_ins,
  output logic       bad_op
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [2:0] STEP_FETCH  = 3'd0;
  localparam logic [2:0] STEP_DECODE = 3'd1;
  localparam logic [2:0] STEP_EXEC   = 3'd2;
  localparam logic [2:0] STEP_MEM    = 3'd3;
  localparam logic [2:0] STEP_WB     = 3'd4;

  logic op_supported;

  // Flag whether the current opcode is one this controller knows how to sequence
  always_comb begin
    op_supported = 1'b0;
    case (Op)
      OP_RTYPE, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J: op_supported = 1'b1;
      default:                                       op_supported = 1'b0;
    endcase
  end

  // Decode step and opcode into strobes; unknown step/opcode pairs fall back to fetch
  always_comb begin
    MemToReg = 1'b0;
    RegDst   = 1'b0;
    IorD     = 1'b0;
    ALUSrcA  = 1'b0;
    ALUSrcB  = 2'b00;
    PCSrc    = 2'b00;
    IRWrite  = 1'b0;
    MemWrite = 1'b0;
    PCWrite  = 1'b0;
    Branch   = 1'b0;
    RegWrite = 1'b0;
    ALUOp    = 2'b00;
    next_ins = 1'b0;
    case (state)
      STEP_FETCH: begin
        IRWrite = 1'b1;
        PCWrite = 1'b1;
        ALUSrcB = 2'b01;
      end
      STEP_DECODE: begin
        ALUSrcB = 2'b11;
      end
      STEP_EXEC: begin
        case (Op)
          OP_RTYPE: begin
            ALUSrcA = 1'b1;
            ALUOp   = 2'b10;
          end
          OP_ADDI, OP_LW, OP_SW: begin
            ALUSrcA = 1'b1;
            ALUSrcB = 2'b10;
          end
          OP_BEQ: begin
            ALUSrcA  = 1'b1;
            ALUOp    = 2'b01;
            Branch   = 1'b1;
            PCSrc    = 2'b01;
            next_ins = 1'b1;
          end
          OP_J: begin
            PCSrc    = 2'b10;
            PCWrite  = 1'b1;
            next_ins = 1'b1;
          end
          default: next_ins = 1'b1;
        endcase
      end
      STEP_MEM: begin
        case (Op)
          OP_RTYPE: begin
            RegDst   = 1'b1;
            RegWrite = 1'b1;
            next_ins = 1'b1;
          end
          OP_ADDI: begin
            RegWrite = 1'b1;
            next_ins = 1'b1;
          end
          OP_LW: begin
            IorD = 1'b1;
          end
          OP_SW: begin
            IorD     = 1'b1;
            MemWrite = 1'b1;
            next_ins = 1'b1;
          end
          default: next_ins = 1'b1;
        endcase
      end
      STEP_WB: begin
        if (Op == OP_LW) begin
          MemToReg = 1'b1;
          RegWrite = 1'b1;
        end
        next_ins = 1'b1;
      end
      default: next_ins = 1'b1;
    endcase
  end

  // Translate ALUOp (and Funct for R-type) into the ALU function code
  always_comb begin
    ALUControl = 3'b010;
    case (ALUOp)
      2'b00: ALUControl = 3'b010;
      2'b01: ALUControl = 3'b110;
      2'b10: begin
        case (Funct)
          6'b100000: ALUControl = 3'b010;
          6'b100010: ALUControl = 3'b110;
          6'b100100: ALUControl = 3'b000;
          6'b100101: ALUControl = 3'b001;
          6'b101010: ALUControl = 3'b111;
          default:   ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b010;
    endcase
  end

  // Latch an unsupported opcode seen at decode until the next reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bad_op <= 1'b0;
    end else if (state == STEP_DECODE && !op_supported) begin
      bad_op <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips_multicycle_controller.sv
// Directed self-checking bench for the multi-cycle MIPS controller.
module tb_mips_multicycle_controller;

  logic       clk;
  logic       rst_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic [2:0] state;
  logic       MemToReg, RegDst, IorD, ALUSrcA;
  logic [1:0] ALUSrcB, PCSrc;
  logic       IRWrite, MemWrite, PCWrite, Branch, RegWrite;
  logic [1:0] ALUOp;
  logic [2:0] ALUControl;
  logic       next_ins;
  logic       bad_op;

  int checks   = 0;
  int failures = 0;

  // Strobe word order: MemToReg RegDst IorD ALUSrcA ALUSrcB PCSrc IRWrite MemWrite PCWrite Branch RegWrite ALUOp
  logic [14:0] strobes;
  assign strobes = {MemToReg, RegDst, IorD, ALUSrcA, ALUSrcB, PCSrc,
                    IRWrite, MemWrite, PCWrite, Branch, RegWrite, ALUOp};

  localparam logic [14:0] S_FETCH   = 15'b0_0_0_0_01_00_1_0_1_0_0_00;
  localparam logic [14:0] S_DECODE  = 15'b0_0_0_0_11_00_0_0_0_0_0_00;
  localparam logic [14:0] S_R_EXEC  = 15'b0_0_0_1_00_00_0_0_0_0_0_10;
  localparam logic [14:0] S_R_WB    = 15'b0_1_0_0_00_00_0_0_0_0_1_00;
  localparam logic [14:0] S_IMM_EX  = 15'b0_0_0_1_10_00_0_0_0_0_0_00;
  localparam logic [14:0] S_BEQ     = 15'b0_0_0_1_00_01_0_0_0_1_0_01;
  localparam logic [14:0] S_J       = 15'b0_0_0_0_00_10_0_0_1_0_0_00;
  localparam logic [14:0] S_ADDI_WB = 15'b0_0_0_0_00_00_0_0_0_0_1_00;
  localparam logic [14:0] S_LW_MEM  = 15'b0_0_1_0_00_00_0_0_0_0_0_00;
  localparam logic [14:0] S_SW_MEM  = 15'b0_0_1_0_00_00_0_1_0_0_0_00;
  localparam logic [14:0] S_LW_WB   = 15'b1_0_0_0_00_00_0_0_0_0_1_00;
  localparam logic [14:0] S_NONE    = 15'b0;

  mips_multicycle_controller dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .Funct(Funct), .state(state),
    .MemToReg(MemToReg), .RegDst(RegDst), .IorD(IorD), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSrc(PCSrc), .IRWrite(IRWrite), .MemWrite(MemWrite),
    .PCWrite(PCWrite), .Branch(Branch), .RegWrite(RegWrite), .ALUOp(ALUOp),
    .ALUControl(ALUControl), .next_ins(next_ins), .bad_op(bad_op)
  );

  // Free-running 10 ns clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic apply_stimulus(input logic [5:0] op, input logic [5:0] funct,
                                input logic [2:0] st);
    @(negedge clk);
    Op    = op;
    Funct = funct;
    state = st;
    #1;
  endtask

  task automatic check_output(input string tag, input logic [14:0] observed,
                              input logic [14:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_step(input string tag, input logic [14:0] exp_strobes,
                            input logic [2:0] exp_alu, input logic exp_next);
    check_output({tag, ".strobes"}, strobes, exp_strobes);
    check_output({tag, ".alu"}, {12'b0, ALUControl}, {12'b0, exp_alu});
    check_output({tag, ".next"}, {14'b0, next_ins}, {14'b0, exp_next});
  endtask

  // Directed sequence
  initial begin
    rst_n = 1'b0;
    Op    = 6'b000000;
    Funct = 6'b100000;
    state = 3'd0;
    @(posedge clk);
    @(posedge clk);
    #1;
    check_output("reset_bad_op", {14'b0, bad_op}, 15'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // R-type add through its four steps
    apply_stimulus(6'b000000, 6'b100000, 3'd0);
    check_step("r_step0", S_FETCH, 3'b010, 1'b0);
    apply_stimulus(6'b000000, 6'b100000, 3'd1);
    check_step("r_step1", S_DECODE, 3'b010, 1'b0);
    apply_stimulus(6'b000000, 6'b100000, 3'd2);
    check_step("r_step2", S_R_EXEC, 3'b010, 1'b0);
    apply_stimulus(6'b000000, 6'b100000, 3'd3);
    check_step("r_step3", S_R_WB, 3'b010, 1'b1);

    // Funct sweep at execute
    apply_stimulus(6'b000000, 6'b100010, 3'd2);
    check_output("funct_sub", {12'b0, ALUControl}, 15'd6);
    apply_stimulus(6'b000000, 6'b100100, 3'd2);
    check_output("funct_and", {12'b0, ALUControl}, 15'd0);
    apply_stimulus(6'b000000, 6'b100101, 3'd2);
    check_output("funct_or", {12'b0, ALUControl}, 15'd1);
    apply_stimulus(6'b000000, 6'b101010, 3'd2);
    check_output("funct_slt", {12'b0, ALUControl}, 15'd7);
    apply_stimulus(6'b000000, 6'b000000, 3'd2);
    check_output("funct_other", {12'b0, ALUControl}, 15'd0);

    // lw through five steps, then one past the end
    apply_stimulus(6'b100011, 6'b000000, 3'd0);
    check_step("lw_step0", S_FETCH, 3'b010, 1'b0);
    apply_stimulus(6'b100011, 6'b000000, 3'd2);
    check_step("lw_step2", S_IMM_EX, 3'b010, 1'b0);
    apply_stimulus(6'b100011, 6'b000000, 3'd3);
    check_step("lw_step3", S_LW_MEM, 3'b010, 1'b0);
    apply_stimulus(6'b100011, 6'b000000, 3'd4);
    check_step("lw_step4", S_LW_WB, 3'b010, 1'b1);
    apply_stimulus(6'b100011, 6'b000000, 3'd5);
    check_step("lw_step5", S_NONE, 3'b010, 1'b1);

    // sw and addi
    apply_stimulus(6'b101011, 6'b000000, 3'd2);
    check_step("sw_step2", S_IMM_EX, 3'b010, 1'b0);
    apply_stimulus(6'b101011, 6'b000000, 3'd3);
    check_step("sw_step3", S_SW_MEM, 3'b010, 1'b1);
    apply_stimulus(6'b001000, 6'b000000, 3'd3);
    check_step("addi_step3", S_ADDI_WB, 3'b010, 1'b1);

    // beq and j at execute, and past their last step
    apply_stimulus(6'b000100, 6'b100101, 3'd2);
    check_step("beq_step2", S_BEQ, 3'b110, 1'b1);
    apply_stimulus(6'b000100, 6'b000000, 3'd3);
    check_step("beq_step3", S_NONE, 3'b010, 1'b1);
    apply_stimulus(6'b000010, 6'b000000, 3'd2);
    check_step("j_step2", S_J, 3'b010, 1'b1);
    apply_stimulus(6'b000000, 6'b100000, 3'd7);
    check_step("r_step7", S_NONE, 3'b010, 1'b1);
    check_output("bad_op_clean", {14'b0, bad_op}, 15'd0);

    // Unsupported opcode: only decode step sets the flag
    apply_stimulus(6'b111111, 6'b000000, 3'd0);
    check_step("bad_step0", S_FETCH, 3'b010, 1'b0);
    @(posedge clk);
    #1;
    check_output("bad_op_step0", {14'b0, bad_op}, 15'd0);
    apply_stimulus(6'b111111, 6'b000000, 3'd1);
    @(posedge clk);
    #1;
    check_output("bad_op_set", {14'b0, bad_op}, 15'd1);
    apply_stimulus(6'b111111, 6'b000000, 3'd2);
    check_step("bad_step2", S_NONE, 3'b010, 1'b1);
    @(posedge clk);
    #1;
    check_output("bad_op_sticky", {14'b0, bad_op}, 15'd1);

    // Reset wins over set while still at decode
    @(negedge clk);
    state = 3'd1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check_output("bad_op_reset", {14'b0, bad_op}, 15'd0);
    check_step("reset_comb", S_DECODE, 3'b010, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_controller.md
Name: mips_multicycle_controller

Overview:
- Control unit of the multi-cycle MIPS CPU.
- Inputs: the instruction opcode/funct (from IR) and the current step number from the datapath step counter.
- Outputs: all datapath control strobes, the ALU control code, and next_ins, which tells the step counter to return to step 0.
- Control decode is purely combinational. The only sequential element is a sticky bad-opcode flag.

Parameters:
- none

Ports:
- clk  in  1  system clock; only the bad_op register uses it
- rst_n  in  1  synchronous, active-low reset
- Op  in  6  instruction[31:26]
- Funct  in  6  instruction[5:0]
- state  in  3  current step, 0..7
- MemToReg  out  1  register write data: 1 = memory data, 0 = ALU result
- RegDst  out  1  destination register: 1 = rd, 0 = rt
- IorD  out  1  memory address: 1 = ALUOut, 0 = PC
- ALUSrcA  out  1  ALU A input: 1 = register A, 0 = PC
- ALUSrcB  out  2  ALU B input: 00 = reg B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate shifted left 2
- PCSrc  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target
- IRWrite  out  1  load IR
- MemWrite  out  1  memory write
- PCWrite  out  1  unconditional PC write
- Branch  out  1  PC write if ALU Zero
- RegWrite  out  1  register file write
- ALUOp  out  2  00 = add, 01 = sub, 10 = use Funct
- ALUControl  out  3  ALU function code
- next_ins  out  1  current step is the instruction's last; step counter returns to 0 next
- bad_op  out  1  sticky flag: an unsupported opcode was decoded

Behaviour:
- Supported opcodes: R-type 000000, addi 001000, lw 100011, sw 101011, beq 000100, j 000010.
- Default: every strobe is 0 and every 2-bit select is 00 unless listed for the step below.
- Outputs depend only on Op, Funct and state; they are valid in the same cycle.
- Step 0 (fetch, all opcodes): IRWrite=1, PCWrite=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00, IorD=0.
- Step 1 (decode, all opcodes): ALUSrcA=0, ALUSrcB=11, ALUOp=00.
- Step 2, by opcode:
  - R-type: ALUSrcA=1, ALUSrcB=00, ALUOp=10.
  - addi, lw, sw: ALUSrcA=1, ALUSrcB=10, ALUOp=00.
  - beq: ALUSrcA=1, ALUSrcB=00, ALUOp=01, Branch=1, PCSrc=01, next_ins=1.
  - j: PCSrc=10, PCWrite=1, next_ins=1.
- Step 3, by opcode:
  - R-type: RegDst=1, MemToReg=0, RegWrite=1, next_ins=1.
  - addi: RegDst=0, MemToReg=0, RegWrite=1, next_ins=1.
  - lw: IorD=1 (memory read).
  - sw: IorD=1, MemWrite=1, next_ins=1.
- Step 4, lw only: RegDst=0, MemToReg=1, RegWrite=1, next_ins=1.
- Any step beyond an opcode's last step, any step 5..7, or any step >=2 with an unsupported opcode: all strobes 0, next_ins=1. This is a recovery path back to fetch.
- ALUControl is decoded from ALUOp:
  - ALUOp 00 -> 010 (add).
  - ALUOp 01 -> 110 (sub).
  - ALUOp 11 -> 010 (add).
  - ALUOp 10 -> decoded from Funct:
    - 100000 -> 010 (add)
    - 100010 -> 110 (sub)
    - 100100 -> 000 (and)
    - 100101 -> 001 (or)
    - 101010 -> 111 (slt)
    - any other Funct -> 000
- bad_op register:
  - At each rising clk with rst_n=0: cleared to 0; reset has priority over setting.
  - Else, if state==1 and Op is unsupported: set to 1.
  - Otherwise: holds its value.
- Reset has no effect on the combinational outputs.

Test Plan:
- R-type, Funct=100000, state 0..3:
  - step 0: IRWrite=1, PCWrite=1, ALUSrcB=01.
  - step 2: ALUOp=10, ALUControl=010.
  - step 3: RegWrite=1, RegDst=1, next_ins=1.
- R-type, step 2, sweep Funct through 100010, 100100, 100101, 101010, 000000 -> ALUControl = 110, 000, 001, 111, 000.
- lw (100011), state 0..4:
  - step 2: ALUSrcB=10.
  - step 3: IorD=1, next_ins=0.
  - step 4: MemToReg=1, RegWrite=1, next_ins=1.
- sw (101011), step 3 -> MemWrite=1, IorD=1, next_ins=1, RegWrite=0. addi (001000), step 3 -> RegWrite=1, RegDst=0, next_ins=1.
- beq and j at step 2:
  - beq (000100): Branch=1, PCSrc=01, ALUControl=110, next_ins=1.
  - j (000010): PCWrite=1, PCSrc=10, next_ins=1.
- Op=111111:
  - hold state=1 across a clk edge -> bad_op=1 after the edge.
  - state=2 -> next_ins=1, all strobes 0.
  - rst_n=0 at the next edge -> bad_op=0.
